// File: rtl/line_burst_adaptor_pkg.sv
// Shared definitions for the cache line <-> memory burst adaptor: state type,
// default geometry and line-address alignment.
package line_burst_adaptor_pkg;

    localparam int unsigned LBA_OFFSET = 5;
    localparam int unsigned LBA_BURST  = 64;
    localparam int unsigned LBA_LINE   = 8 << LBA_OFFSET;
    localparam int unsigned LBA_BEATS  = LBA_LINE / LBA_BURST;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } lba_state_e;

    // Clear the byte-within-line bits of an address.
    function automatic logic [31:0] align_line_addr(input logic [31:0] addr,
                                                    input int unsigned offset);
        logic [31:0] mask;
        mask = '1;
        mask = mask << offset;
        return addr & mask;
    endfunction

endpackage

// File: rtl/line_burst_adaptor_beat_counter.sv
// line_beat_counter: beat index within a burst, with clear, enable and a
// last-beat flag; wraps to zero on the final beat.
module line_beat_counter
    import line_burst_adaptor_pkg::*;
#(
    parameter int unsigned BEATS = LBA_BEATS,
    parameter int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_nxt_c,
    output logic          last_c
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last_c = (count_q == CW'(BEATS - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = last_c ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign count_nxt_c = count_d;

endmodule

// File: rtl/line_burst_adaptor.sv
// Fill/write-back bridge between a full cache line and a 64-bit burst memory bus.
// Optional LINE_BURST_ADAPTOR_PERF_EN adds saturating completed-line counters.
module line_burst_adaptor
    import line_burst_adaptor_pkg::*;
#(
    parameter int unsigned s_offset = LBA_OFFSET,
    parameter int unsigned s_burst  = LBA_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read_i,
    input  logic                       write_i,
    input  logic [31:0]                address_i,
    input  logic [(8<<s_offset)-1:0]   line_i,
    output logic [(8<<s_offset)-1:0]   line_o,
    output logic [(1<<s_offset)-1:0]   fill_we_o,
    output logic                       resp_o,
    output logic                       pmem_read_o,
    output logic                       pmem_write_o,
    output logic [31:0]                pmem_address_o,
    output logic [s_burst-1:0]         pmem_wdata_o,
    input  logic [s_burst-1:0]         pmem_rdata_i,
    input  logic                       pmem_resp_i
`ifdef LINE_BURST_ADAPTOR_PERF_EN
    ,
    output logic [31:0]                rd_lines_o,
    output logic [31:0]                wr_lines_o
`endif
);

    localparam int unsigned S_LINE = 8 << s_offset;
    localparam int unsigned WE_W   = 1 << s_offset;
    localparam int unsigned BEATS  = S_LINE / s_burst;
    localparam int unsigned CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    lba_state_e          state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [S_LINE-1:0]   wline_q, wline_d;
    logic [S_LINE-1:0]   line_q, line_d;
    logic                resp_q, resp_d;
    logic [WE_W-1:0]     fwe_q, fwe_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [s_burst-1:0]  wdata_q, wdata_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_nxt;
    logic                cnt_last;

    line_beat_counter #(
        .BEATS (BEATS),
        .CW    (CW)
    ) u_beat_counter (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr),
        .en_i        (cnt_en),
        .count_o     (cnt_q),
        .count_nxt_c (cnt_nxt),
        .last_c      (cnt_last)
    );

    // Next state, request latching and fill-line assembly.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        line_d  = line_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = align_line_addr(address_i, s_offset);
                    wline_d = line_i;
                    cnt_clr = 1'b1;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = align_line_addr(address_i, s_offset);
                    cnt_clr = 1'b1;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (pmem_resp_i) begin
                    line_d[32'(cnt_q) * s_burst +: s_burst] = pmem_rdata_i;
                    cnt_en = 1'b1;
                    if (cnt_last) state_d = RD_DONE;
                end
            end
            WR_BURST: begin
                if (pmem_resp_i) begin
                    cnt_en = 1'b1;
                    if (cnt_last) state_d = WR_DONE;
                end
            end
            RD_DONE, WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs describe the state being entered, so strobes lead by no extra cycle.
    always_comb begin
        rd_d    = (state_d == RD_BURST);
        wr_d    = (state_d == WR_BURST);
        resp_d  = (state_d == RD_DONE) || (state_d == WR_DONE);
        fwe_d   = '0;
        wdata_d = '0;
        if (state_d == RD_DONE) fwe_d = '1;
        if (wr_d) wdata_d = wline_d[32'(cnt_nxt) * s_burst +: s_burst];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
            resp_q  <= 1'b0;
            fwe_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            line_q  <= line_d;
            resp_q  <= resp_d;
            fwe_q   <= fwe_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign line_o         = line_q;
    assign fill_we_o      = fwe_q;
    assign resp_o         = resp_q;
    assign pmem_read_o    = rd_q;
    assign pmem_write_o   = wr_q;
    assign pmem_address_o = addr_q;
    assign pmem_wdata_o   = wdata_q;

`ifdef LINE_BURST_ADAPTOR_PERF_EN
    logic [31:0] rd_lines_q, rd_lines_d;
    logic [31:0] wr_lines_q, wr_lines_d;

    // Completed-line counters, bumped on DONE entry and saturating.
    always_comb begin
        rd_lines_d = rd_lines_q;
        wr_lines_d = wr_lines_q;
        if (state_d == RD_DONE && state_q != RD_DONE && rd_lines_q != '1)
            rd_lines_d = rd_lines_q + 32'd1;
        if (state_d == WR_DONE && state_q != WR_DONE && wr_lines_q != '1)
            wr_lines_d = wr_lines_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_lines_q <= '0;
            wr_lines_q <= '0;
        end else begin
            rd_lines_q <= rd_lines_d;
            wr_lines_q <= wr_lines_d;
        end
    end

    assign rd_lines_o = rd_lines_q;
    assign wr_lines_o = wr_lines_q;
`endif

endmodule

// File: doc/line_burst_adaptor.md
# line_burst_adaptor

Bridges the cache's full-line datapath and the 64-bit burst physical-memory bus. On a miss it collects four memory beats into one cache line and presents it, with an all-ones byte-enable, to the cache data array write port. On a dirty eviction it splits a line from the data array read port into four beats. It sits directly upstream of the cache data array on the fill path and downstream of it on the write-back path.

## Interface
- s_offset, 5, log2 of line bytes; line width s_line = 8·2^s_offset
- s_burst, 64, memory beat width in bits; number of beats = s_line/s_burst (4 at defaults)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- read_i  in  1  fill request from cache controller (level, held until resp_o)
- write_i  in  1  write-back request (level, held until resp_o)
- address_i  in  32  byte address of the line
- line_i  in  s_line  line to write back (data array dataout)
- line_o  out  s_line  assembled fill line (data array datain)
- fill_we_o  out  2^s_offset  byte write-enable toward data array
- resp_o  out  1  one-cycle completion pulse
- pmem_read_o  out  1  memory read strobe
- pmem_write_o  out  1  memory write strobe
- pmem_address_o  out  32  line-aligned address
- pmem_wdata_o  out  s_burst  write beat
- pmem_rdata_i  in  s_burst  read beat
- pmem_resp_i  in  1  beat accepted/valid

## Operation
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - write_i=1 → latch aligned address (low s_offset bits zeroed) and line_i, clear beat counter, go WR_BURST.
  - else read_i=1 → latch aligned address, clear counter, go RD_BURST.
  - Write wins if both are asserted.
- RD_BURST: pmem_read_o=1. Each cycle with pmem_resp_i=1 stores pmem_rdata_i into line slot [counter] (beat 0 = bits s_burst-1:0) and increments the counter. After the last beat, go RD_DONE.
- RD_DONE, one cycle: resp_o=1 and fill_we_o=all ones, with line_o holding the full line. Then go IDLE.
- WR_BURST: pmem_write_o=1 and pmem_wdata_o = latched line slot [counter]. Advance on pmem_resp_i. After the last beat, go WR_DONE.
- WR_DONE, one cycle: resp_o=1 and fill_we_o=0. Then go IDLE.
- pmem_address_o is the latched aligned address for the whole burst; it is held constant across beats.
- pmem_resp_i is ignored in IDLE and in both DONE states.
- Counter width is log2(beats). Wrap-around on the final beat is the trigger to leave the burst state.
- fill_we_o is 0 in every state other than RD_DONE.

## Timing
- Reset (rst low, asynchronous) forces the following immediately:
  - state IDLE, counter 0
  - resp_o, fill_we_o, pmem_read_o, pmem_write_o all 0
  - pmem_address_o, pmem_wdata_o, line_o all 0
- Reset mid-burst abandons the transaction. No resp_o is issued, and memory strobes drop in the same cycle.
- Strobes are registered and assert the cycle after the request is seen in IDLE.
- Minimum latency: request at cycle 0, beats at cycles 1–4 (pmem_resp_i every cycle), resp_o at cycle 5.
- Stalls are unbounded; strobes stay high until the final beat.
- The requester must drop read_i/write_i in the cycle after resp_o. A request still high in IDLE starts a new transaction.
- line_o keeps its last assembled value until the next read burst overwrites slots.

## Configuration
- LINE_BURST_ADAPTOR_PERF_EN defined:
  - Adds ports rd_lines_o and wr_lines_o, each 32 bits.
  - Each increments on entry to RD_DONE or WR_DONE respectively, and saturates at all ones.
  - Both reset to 0.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared cache package holds:
  - state enum type
  - beat-count constant (s_line/s_burst)
  - address-alignment helper function
- One sub-module, line_beat_counter: log2(beats)-bit up-counter with clear, enable and last-beat flag. The FSM and line assembly/disassembly stay in the top module.

## Test plan
- Fill, no stall: address_i=0x0000_1234, beats 0x11…, 0x22…, 0x33…, 0x44… on consecutive cycles → pmem_address_o=0x0000_1220; resp_o at cycle 5; line_o = {0x44…,0x33…,0x22…,0x11…}; fill_we_o=0xFFFF_FFFF for exactly one cycle.
- Write-back with 3-cycle gaps between pmem_resp_i → pmem_wdata_o steps through line_i slots 0..3 only on resp edges; resp_o once; fill_we_o stays 0.
- read_i and write_i asserted together → write burst runs first. pmem_read_o stays 0 until after WR_DONE, then the fill starts because read_i is still held.
- rst pulled low after beat 2 of a fill → strobes drop immediately; no resp_o. A fill issued after release completes normally with counter starting at 0.
- pmem_resp_i pulsed while IDLE → no state change, no output change.
- Build with LINE_BURST_ADAPTOR_PERF_EN: 3 fills then 2 write-backs → rd_lines_o=3, wr_lines_o=2. Counter preloaded near max saturates at 0xFFFF_FFFF.
